// File: rtl/ldtu_ser_nlane_if.sv
// Parallel-word / serial-lane bundle between the LiTE-DTU datapath (master)
// and the N-lane serializer (slave).
interface ldtu_ser_nlane_if #(
  parameter int NLANES = 4,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic [NLANES*WORD_W-1:0] data_in;
  logic [NLANES-1:0]        data_valid;
  logic [NLANES-1:0]        lane_enable;
  logic                     training_mode;
  logic                     clear_cnt;
  logic                     handshake;
  logic [NLANES-1:0]        data_out;
  logic [NLANES*CNT_W-1:0]  underrun_cnt;

  modport master (
    output data_in, data_valid, lane_enable, training_mode, clear_cnt,
    input  handshake, data_out, underrun_cnt
  );

  modport slave (
    input  data_in, data_valid, lane_enable, training_mode, clear_cnt,
    output handshake, data_out, underrun_cnt
  );
endinterface

// File: rtl/ldtu_ser_nlane.sv
// N-lane MSB-first word serializer with shared bit counter, word-boundary
// handshake, per-lane enable, idle/training insertion and underrun counters.
module ldtu_ser_nlane #(
  parameter int          NLANES       = 4,
  parameter int          WORD_W       = 32,
  parameter logic [31:0] IDLE_PATTERN = 32'hEAAAAAAA,
  parameter int          CNT_W        = 16
) (
  input  logic             clock,
  input  logic             rst_b,
  ldtu_ser_nlane_if.slave  bus
);

  localparam int                BCW     = $clog2(WORD_W);
  localparam logic [BCW-1:0]    LAST    = BCW'(WORD_W - 1);
  localparam logic [BCW-1:0]    PRE     = BCW'(WORD_W - 2);
  localparam logic [WORD_W-1:0] IDLE_W  = WORD_W'(IDLE_PATTERN);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [BCW-1:0]          r_bit_cnt;
  logic                    r_handshake;
  logic                    w_load;
  logic [NLANES-1:0]       w_data_out;
  logic [NLANES*CNT_W-1:0] w_underrun_cnt;

  // The load edge is the edge that closes the cycle where the counter is at
  // its last value, i.e. the edge ending the handshake pulse.
  assign w_load = (r_bit_cnt == LAST);

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + BCW'(1);
    end
  end

  // Registered so it is high exactly while the counter sits at WORD_W-1.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_handshake <= 1'b0;
    end else begin
      r_handshake <= (r_bit_cnt == PRE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      logic [WORD_W-1:0] r_shift;
      logic              r_en;
      logic [CNT_W-1:0]  r_cnt;
      logic [WORD_W-1:0] w_word;
      logic              w_underrun;

      always_comb begin
        w_word     = '0;
        w_underrun = 1'b0;
        if (bus.lane_enable[gi]) begin
          if (bus.training_mode) begin
            w_word = IDLE_W;
          end else if (bus.data_valid[gi]) begin
            w_word = bus.data_in[gi*WORD_W +: WORD_W];
          end else begin
            w_word     = IDLE_W;
            w_underrun = 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
          r_shift <= '0;
          r_en    <= 1'b0;
        end else if (w_load) begin
          r_shift <= w_word;
          r_en    <= bus.lane_enable[gi];
        end else begin
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
        end
      end

      // Clear has priority over a coincident underrun; the count never wraps.
      always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
          r_cnt <= '0;
        end else if (bus.clear_cnt) begin
          r_cnt <= '0;
        end else if (w_load && w_underrun && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_data_out[gi]                   = r_shift[WORD_W-1] & r_en;
      assign w_underrun_cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign bus.handshake    = r_handshake;
  assign bus.data_out     = w_data_out;
  assign bus.underrun_cnt = w_underrun_cnt;

endmodule

// File: tb/tb_ldtu_ser_nlane.sv
// Scoreboard bench for ldtu_ser_nlane: words are predicted at each boundary
// from the lane rules and compared against the reassembled serial streams.
module tb_ldtu_ser_nlane;
  localparam int          NL   = 4;
  localparam int          WW   = 32;
  localparam int          CW   = 4;
  localparam logic [31:0] IDLE = 32'hEAAAAAAA;
  localparam int          NW   = 48;
  localparam int          RST_W = 40;

  typedef struct packed {
    logic [NL*WW-1:0] words;
    logic [NL*CW-1:0] cnts;
  } exp_t;

  logic clock = 1'b0;
  logic rst_b = 1'b0;
  always #5 clock = ~clock;

  ldtu_ser_nlane_if #(.NLANES(NL), .WORD_W(WW), .CNT_W(CW)) bus ();

  ldtu_ser_nlane #(
    .NLANES(NL), .WORD_W(WW), .IDLE_PATTERN(IDLE), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .rst_b(rst_b),
    .bus  (bus)
  );

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            edge_n;
  int            mcnt[NL];
  logic [WW-1:0] acc[NL];

  // Edges since reset release: the reference timeline for handshake and bits.
  always @(posedge clock or negedge rst_b) begin
    if (!rst_b) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clock) begin : mon_p
    exp_t e;
    logic want_hs;
    if (rst_b) begin
      want_hs = ((edge_n % WW) == WW - 1);
      n_tests++;
      if (bus.handshake !== want_hs) begin
        n_fail++;
        $display("FAIL handshake edge=%0d got=%b want=%b", edge_n, bus.handshake, want_hs);
      end
      if (edge_n < WW) begin
        n_tests++;
        if (bus.data_out !== '0) begin
          n_fail++;
          $display("FAIL idle_before_first_load edge=%0d got=%b want=0", edge_n, bus.data_out);
        end
      end else begin
        for (int i = 0; i < NL; i++) acc[i] = {acc[i][WW-2:0], bus.data_out[i]};
        if ((edge_n % WW) == WW - 1) begin
          n_tests++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty edge=%0d got=word want=no_word", edge_n);
          end else begin
            e = sb_q.pop_front();
            $display("[TB] word edge=%0d lanes=%h %h %h %h cnt=%h", edge_n,
                     acc[3], acc[2], acc[1], acc[0], bus.underrun_cnt);
            for (int i = 0; i < NL; i++) begin
              n_tests++;
              if (acc[i] !== e.words[i*WW +: WW]) begin
                n_fail++;
                $display("FAIL lane%0d_word got=%h want=%h", i, acc[i], e.words[i*WW +: WW]);
              end
              n_tests++;
              if (bus.underrun_cnt[i*CW +: CW] !== e.cnts[i*CW +: CW]) begin
                n_fail++;
                $display("FAIL lane%0d_underrun got=%0d want=%0d", i,
                         bus.underrun_cnt[i*CW +: CW], e.cnts[i*CW +: CW]);
              end
            end
          end
        end
      end
    end
  end

  // Stimulus for word w, applied just before the load edge, plus its prediction.
  task automatic drive_word(input int w);
    logic [NL-1:0]    en, val;
    logic             tr, clr;
    logic [NL*WW-1:0] d;
    logic [WW-1:0]    di, ew;
    exp_t             e;
    en = 4'hF; val = 4'hF; tr = 1'b0; clr = 1'b0;
    for (int i = 0; i < NL; i++) d[i*WW +: WW] = 32'h12345678 + 32'(i);
    if (w >= 4 && w <= 6)        val = 4'b1011;
    else if (w >= 7 && w <= 8)   tr = 1'b1;
    else if (w >= 9 && w <= 10)  en = 4'b0111;
    else if (w >= 11) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (w <= 31) begin
        val = 4'b1110;
        clr = (w == 31);
      end else begin
        en  = NL'($urandom);
        val = NL'($urandom);
        tr  = ($urandom_range(0, 3) == 0);
        clr = ($urandom_range(0, 7) == 0);
      end
    end
    bus.lane_enable = en; bus.data_valid = val; bus.training_mode = tr;
    bus.clear_cnt = clr; bus.data_in = d;
    for (int i = 0; i < NL; i++) begin
      di = d[i*WW +: WW];
      if (!en[i])       ew = '0;
      else if (tr)      ew = IDLE;
      else if (val[i])  ew = di;
      else begin
        ew = IDLE;
        if (mcnt[i] < (1 << CW) - 1) mcnt[i]++;
      end
      e.words[i*WW +: WW] = ew;
    end
    if (clr) for (int i = 0; i < NL; i++) mcnt[i] = 0;
    for (int i = 0; i < NL; i++) e.cnts[i*CW +: CW] = CW'(mcnt[i]);
    sb_q.push_back(e);
  endtask

  task automatic wait_phase(input int ph);
    int g = 0;
    while ((edge_n % WW) != ph && g < 4 * WW) begin
      @(negedge clock);
      g++;
    end
    if (g >= 4 * WW) begin
      n_fail++;
      $display("FAIL phase_timeout got=%0d want=%0d", edge_n % WW, ph);
    end
  endtask

  initial begin
    bus.data_in = '0; bus.data_valid = '0; bus.lane_enable = '0;
    bus.training_mode = 1'b0; bus.clear_cnt = 1'b0;
    for (int i = 0; i < NL; i++) begin mcnt[i] = 0; acc[i] = '0; end
    repeat (3) @(negedge clock);
    n_tests++;
    if (bus.handshake !== 1'b0 || bus.data_out !== '0 || bus.underrun_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%h want=0/0/0", bus.handshake, bus.data_out, bus.underrun_cnt);
    end
    rst_b = 1'b1;
    for (int w = 0; w < NW; w++) begin
      wait_phase(WW - 1);
      drive_word(w);
      @(negedge clock);
      bus.clear_cnt = 1'b0;
      wait_phase(10);
      // Mid-word changes must not leak into the word already loaded.
      bus.lane_enable   = ~bus.lane_enable;
      bus.data_valid    = ~bus.data_valid;
      bus.training_mode = ~bus.training_mode;
      bus.data_in       = {$urandom, $urandom, $urandom, $urandom};
      if (w == RST_W) begin
        #2 rst_b = 1'b0;
        #1;
        n_tests++;
        if (bus.data_out !== '0 || bus.handshake !== 1'b0) begin
          n_fail++;
          $display("FAIL async_reset got=%b/%b want=0/0", bus.data_out, bus.handshake);
        end
        n_tests++;
        if (bus.underrun_cnt !== '0) begin
          n_fail++;
          $display("FAIL async_reset_cnt got=%h want=0", bus.underrun_cnt);
        end
        sb_q.delete();
        for (int i = 0; i < NL; i++) mcnt[i] = 0;
        repeat (2) @(negedge clock);
        rst_b = 1'b1;
      end
    end
    wait_phase(WW - 1);
    @(negedge clock);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ldtu_ser_nlane.md
Name: ldtu_ser_nlane

Overview:
- Parametrised successor to the fixed 4-lane, 32-bit output serializer of the LiTE-DTU datapath.
- Takes NLANES parallel words from the datapath and shifts each out MSB-first on its own serial line.
- Issues the word-boundary handshake to the datapath.
- Adds features the fixed serializer lacks: per-lane enable, idle-pattern insertion when data is not valid, a training mode, and saturating per-lane underrun counters.

Parameters:
- NLANES, 4, number of serial output lanes.
- WORD_W, 32, bits per word (≥4).
- IDLE_PATTERN, 32'hEAAAAAAA, word sent on idle/training; truncated to its WORD_W LSBs.
- CNT_W, 16, width of each underrun counter.

Ports:
- clock  in  1  serializer clock.
- rst_b  in  1  asynchronous, active-low reset.
- data_in  in  NLANES*WORD_W  lane i word = data_in[i*WORD_W +: WORD_W].
- data_valid  in  NLANES  per-lane word valid.
- lane_enable  in  NLANES  per-lane enable.
- training_mode  in  1  force IDLE_PATTERN on all enabled lanes.
- clear_cnt  in  1  synchronous clear of all underrun counters.
- handshake  out  1  word-boundary strobe to the datapath.
- data_out  out  NLANES  serial data, one bit per lane.
- underrun_cnt  out  NLANES*CNT_W  lane i count = underrun_cnt[i*CNT_W +: CNT_W].

Behaviour:
- Single clock domain, clock. rst_b is asynchronous, active-low.
- Reset values:
  - bit counter = 0
  - all shift registers = 0, so data_out = 0
  - handshake = 0
  - underrun counters = 0
  - lane-enable shadow = 0
- Shared bit counter:
  - Counts 0..WORD_W-1 and wraps to 0.
  - Free-running from the first edge after reset release.
- handshake:
  - A registered output, high for exactly one cycle: the cycle in which counter == WORD_W-1.
  - Period is WORD_W cycles.
  - First assertion comes WORD_W-1 cycles after reset release.
- Load edge: the rising edge that ends the handshake cycle. At this edge, for each lane i:
  - The lane_enable[i] shadow is updated from lane_enable[i].
  - If lane_enable[i]=0: load 0. The lane outputs constant 0 for the whole word.
  - Else if training_mode=1: load IDLE_PATTERN.
  - Else if data_valid[i]=1: load data_in lane i.
  - Else: load IDLE_PATTERN and increment underrun counter i.
- Shift: on every non-load edge, each shift register shifts left by 1, zero-filling the LSB.
- data_out[i] = shift register i MSB, taken directly from the register with no extra delay.
  - Word bit k appears in the cycle where counter == WORD_W-1-k.
  - The MSB therefore appears in the cycle immediately after the load edge (counter == 0).
- Latency from load edge to last bit (LSB) on data_out: WORD_W cycles.
- Sampling rules:
  - data_in, data_valid, training_mode and lane_enable are sampled only at the load edge.
  - Changes mid-word have no effect until the next boundary.
- Underrun counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - No increment when the lane is disabled or training_mode=1.
  - clear_cnt=1 zeroes every counter on that edge. If clear and increment happen on the same edge, clear wins (result 0).
- Reset asserted mid-word:
  - All state returns immediately to reset values; the partial word is discarded.
  - After release, the timing restarts exactly as from power-up.
- Widths: all counters are unsigned. The bit counter is $clog2(WORD_W) bits.

Test Plan:
1. Reset, then NLANES=4, WORD_W=32, data_valid=4'hF, lane i word = 32'h12345678+i, held constant → handshake pulses every 32 cycles, first pulse 31 cycles after release. Lane 0 serial stream reconstructs 32'h12345678 MSB-first, starting the cycle after the load edge. Underrun counters stay 0.
2. data_valid=4'b1011 for 3 words → lane 2 sends 32'hEAAAAAAA three times and underrun_cnt lane 2 = 3. Other lanes send their data and their counts stay 0.
3. training_mode=1 with data_valid=4'hF → all enabled lanes send 32'hEAAAAAAA and no counter increments. Deasserting training_mode mid-word changes nothing until the next load edge.
4. lane_enable=4'b0111, with lane_enable[3] toggled mid-word → data_out[3] stays 0 for the whole disabled word. The toggle takes effect only at the following boundary.
5. CNT_W=4, lane 0 invalid for 20 words → count saturates at 15. Asserting clear_cnt on the same edge as an underrun gives 0.
6. rst_b pulsed low at counter == 10 with a word in flight → data_out=0 and handshake=0 immediately. The next handshake comes 31 cycles after release.
